// File: rtl/jump_pkg.sv
// Shared definitions for the jump/branch unit.
//   - Opcode constants for the six control-transfer operations.
//   - FSM state enumeration used by jump_branch_unit.
//   - is_ctrl_op(): true for any of the six control-transfer opcodes.
package jump_pkg;

  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_JR   = 6'b001000;
  localparam logic [5:0] OP_JALR = 6'b001001;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;

  // Architectural return-address register used by JAL.
  localparam logic [4:0] RA_REG = 5'd31;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SLOT  = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  function automatic logic is_ctrl_op(input logic [5:0] op);
    return op inside {OP_J, OP_JAL, OP_JR, OP_JALR, OP_BEQ, OP_BNE};
  endfunction

endpackage

// File: rtl/jump_target_calc.sv
// Combinational target/condition evaluation for one instruction.
// Ports:
//   op, pc, rs_val, rt_val, target, imm : instruction fields and operands
//   target_pc : transfer destination (pc+4 for non-control ops)
//   is_ctrl   : op is one of the six control-transfer opcodes
//   taken     : transfer happens (jumps always, branches on condition,
//               register jumps only when the target is word aligned)
//   misalign  : register jump whose target has nonzero bits [1:0]
module jump_target_calc
  import jump_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int TARGET_W = 26
) (
  input  logic [5:0]          op,
  input  logic [XLEN-1:0]     pc,
  input  logic [XLEN-1:0]     rs_val,
  input  logic [XLEN-1:0]     rt_val,
  input  logic [TARGET_W-1:0] target,
  input  logic [15:0]         imm,
  output logic [XLEN-1:0]     target_pc,
  output logic                is_ctrl,
  output logic                taken,
  output logic                misalign
);

  // J-type keeps the top four bits of pc+4 (the 256 MB region).
  localparam logic [XLEN-1:0] REGION_MASK = {4'hF, {(XLEN-4){1'b0}}};

  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] jump_target;
  logic [XLEN-1:0] branch_target;

  // All additions are XLEN wide, so PC arithmetic wraps naturally.
  assign pc_plus4      = pc + XLEN'(4);
  assign jump_target   = (pc_plus4 & REGION_MASK) | (XLEN'(target) << 2);
  assign branch_target = pc_plus4 + {{(XLEN-18){imm[15]}}, imm, 2'b00};

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    target_pc = pc_plus4;
    taken     = 1'b0;
    misalign  = 1'b0;
    is_ctrl   = is_ctrl_op(op);
    case (op)
      OP_J, OP_JAL: begin
        target_pc = jump_target;
        taken     = 1'b1;
      end
      OP_BEQ: begin
        target_pc = branch_target;
        taken     = (rs_val == rt_val);
      end
      OP_BNE: begin
        target_pc = branch_target;
        taken     = (rs_val != rt_val);
      end
      OP_JR, OP_JALR: begin
        target_pc = rs_val;
        misalign  = |rs_val[1:0];
        taken     = ~(|rs_val[1:0]);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/jump_branch_unit.sv
// Jump/branch resolution unit with optional MIPS delay slot.
// Ports:
//   clk, rst        : rising-edge clock, synchronous active-high reset
//   in_valid/ready  : instruction handshake (accept = in_valid & in_ready)
//   op, pc, rs_val, rt_val, target, imm, link_rd : instruction fields
//   redirect_valid/redirect_pc : fetch redirect pulse and destination
//   link_we/link_addr/link_data : return-address write pulse
//   misalign        : register jump to a non-word-aligned address
//   slot_err        : control op found in a delay slot (not executed)
// DELAY_SLOT=1 holds a taken target until the next accepted instruction;
// DELAY_SLOT=0 redirects at once and inserts a one-cycle bubble.
module jump_branch_unit
  import jump_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int TARGET_W    = 26,
  parameter int LINK_OFFSET = 8,
  parameter int DELAY_SLOT  = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [5:0]          op,
  input  logic [XLEN-1:0]     pc,
  input  logic [XLEN-1:0]     rs_val,
  input  logic [XLEN-1:0]     rt_val,
  input  logic [TARGET_W-1:0] target,
  input  logic [15:0]         imm,
  input  logic [4:0]          link_rd,
  output logic                redirect_valid,
  output logic [XLEN-1:0]     redirect_pc,
  output logic                link_we,
  output logic [4:0]          link_addr,
  output logic [XLEN-1:0]     link_data,
  output logic                misalign,
  output logic                slot_err
);

  state_e          state, state_nxt;
  logic            accept;
  logic [XLEN-1:0] pend_pc;
  logic [XLEN-1:0] calc_pc;
  logic            calc_is_ctrl;
  logic            calc_taken;
  logic            calc_misalign;

  jump_target_calc #(
    .XLEN     (XLEN),
    .TARGET_W (TARGET_W)
  ) u_calc (
    .op        (op),
    .pc        (pc),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .target    (target),
    .imm       (imm),
    .target_pc (calc_pc),
    .is_ctrl   (calc_is_ctrl),
    .taken     (calc_taken),
    .misalign  (calc_misalign)
  );

  assign accept = in_valid & in_ready;

  always_comb begin
    in_ready  = (state != ST_FLUSH);
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept && calc_taken)
                  state_nxt = (DELAY_SLOT != 0) ? ST_SLOT : ST_FLUSH;
      ST_SLOT:  if (accept) state_nxt = ST_IDLE;
      ST_FLUSH: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the pending target is cleared too, so a redirect can never
      // escape from a slot that reset interrupted.
      pend_pc        <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      link_we        <= 1'b0;
      link_addr      <= '0;
      link_data      <= '0;
      misalign       <= 1'b0;
      slot_err       <= 1'b0;
    end else begin
      redirect_valid <= 1'b0;
      link_we        <= 1'b0;
      misalign       <= 1'b0;
      slot_err       <= 1'b0;
      if (accept) begin
        if (state == ST_SLOT) begin
          // Slot instruction completes; a control op here is flagged only.
          redirect_valid <= 1'b1;
          redirect_pc    <= pend_pc;
          slot_err       <= calc_is_ctrl;
        end else begin
          misalign <= calc_misalign;
          if (calc_taken) begin
            if (DELAY_SLOT != 0) begin
              pend_pc <= calc_pc;
            end else begin
              redirect_valid <= 1'b1;
              redirect_pc    <= calc_pc;
            end
          end
          if (op == OP_JAL) begin
            link_we   <= 1'b1;
            link_addr <= RA_REG;
            link_data <= pc + XLEN'(LINK_OFFSET);
          end else if (op == OP_JALR && !calc_misalign && link_rd != '0) begin
            link_we   <= 1'b1;
            link_addr <= link_rd;
            link_data <= pc + XLEN'(LINK_OFFSET);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_jump_branch_unit.sv
// Self-checking bench: three instances (32-bit delay slot, 32-bit flush,
// 64-bit delay slot) share one stimulus bus. Directed scenarios use
// hand-derived constants; the random scenario uses a cycle model.
module tb_jump_branch_unit;

  localparam logic [5:0] T_J = 6'b000010, T_JAL = 6'b000011, T_JR = 6'b001000;
  localparam logic [5:0] T_JALR = 6'b001001, T_BEQ = 6'b000100, T_BNE = 6'b000101;
  localparam logic [5:0] T_NOP = 6'b100000, T_ALU = 6'b100011;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [5:0]  op = T_NOP;
  logic [63:0] pc = '0, rs_val = '0, rt_val = '0;
  logic [25:0] target = '0;
  logic [15:0] imm = '0;
  logic [4:0]  link_rd = '0;

  logic        rdy0, rv0, lwe0, mis0, se0;
  logic [31:0] rpc0, ld0;
  logic [4:0]  la0;
  logic        rdy1, rv1, lwe1, mis1, se1;
  logic [31:0] rpc1, ld1;
  logic [4:0]  la1;
  logic        rdy2, rv2, lwe2, mis2, se2;
  logic [63:0] rpc2, ld2;
  logic [4:0]  la2;

  jump_branch_unit #(.XLEN(32), .DELAY_SLOT(1)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .op(op),
    .pc(pc[31:0]), .rs_val(rs_val[31:0]), .rt_val(rt_val[31:0]),
    .target(target), .imm(imm), .link_rd(link_rd),
    .redirect_valid(rv0), .redirect_pc(rpc0), .link_we(lwe0),
    .link_addr(la0), .link_data(ld0), .misalign(mis0), .slot_err(se0));

  jump_branch_unit #(.XLEN(32), .DELAY_SLOT(0)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .op(op),
    .pc(pc[31:0]), .rs_val(rs_val[31:0]), .rt_val(rt_val[31:0]),
    .target(target), .imm(imm), .link_rd(link_rd),
    .redirect_valid(rv1), .redirect_pc(rpc1), .link_we(lwe1),
    .link_addr(la1), .link_data(ld1), .misalign(mis1), .slot_err(se1));

  jump_branch_unit #(.XLEN(64), .DELAY_SLOT(1)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2), .op(op),
    .pc(pc), .rs_val(rs_val), .rt_val(rt_val),
    .target(target), .imm(imm), .link_rd(link_rd),
    .redirect_valid(rv2), .redirect_pc(rpc2), .link_we(lwe2),
    .link_addr(la2), .link_data(ld2), .misalign(mis2), .slot_err(se2));

  // Uniform views of the three instances for the random scenario.
  logic        o_rdy[3], o_rv[3], o_lwe[3], o_mis[3], o_se[3];
  logic [63:0] o_rpc[3], o_ld[3];
  logic [4:0]  o_la[3];
  always_comb begin
    o_rdy = '{rdy0, rdy1, rdy2};
    o_rv  = '{rv0, rv1, rv2};
    o_lwe = '{lwe0, lwe1, lwe2};
    o_mis = '{mis0, mis1, mis2};
    o_se  = '{se0, se1, se2};
    o_rpc = '{{32'b0, rpc0}, {32'b0, rpc1}, rpc2};
    o_ld  = '{{32'b0, ld0}, {32'b0, ld1}, ld2};
    o_la  = '{la0, la1, la2};
  end

  // Reference model state: a pending slot target and a bubble flag per unit.
  logic        m_slot[3], m_bub[3];
  logic [63:0] m_pend[3];
  logic        e_rdy[3], e_rv[3], e_lwe[3], e_mis[3], e_se[3];
  logic [63:0] e_rpc[3], e_ld[3];
  logic [4:0]  e_la[3];

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [5:0] o, input logic [63:0] p, input logic [63:0] rs,
                       input logic [63:0] rt, input logic [25:0] t, input logic [15:0] i,
                       input logic [4:0] rd);
    in_valid = 1'b1; op = o; pc = p; rs_val = rs; rt_val = rt;
    target = t; imm = i; link_rd = rd;
  endtask

  task automatic idle;
    in_valid = 1'b0;
    op = T_NOP;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic model_reset(input int k);
    m_slot[k] = 1'b0; m_bub[k] = 1'b0; m_pend[k] = '0;
    e_rdy[k] = 1'b1; e_rv[k] = 1'b0; e_lwe[k] = 1'b0; e_mis[k] = 1'b0; e_se[k] = 1'b0;
    e_rpc[k] = '0; e_ld[k] = '0; e_la[k] = '0;
  endtask

  // One clock of behaviour for unit k given the inputs currently driven.
  task automatic model_step(input int k);
    logic [63:0] m, p4, t;
    longint      sx;
    int          w;
    logic        acc, take, ctl;
    w = (k == 2) ? 64 : 32;
    m = (k == 2) ? '1 : 64'hFFFF_FFFF;
    if (rst) begin
      model_reset(k);
      return;
    end
    e_rv[k] = 1'b0; e_lwe[k] = 1'b0; e_mis[k] = 1'b0; e_se[k] = 1'b0;
    acc = in_valid && !m_bub[k];
    m_bub[k] = 1'b0;
    if (acc) begin
      ctl = op inside {T_J, T_JAL, T_JR, T_JALR, T_BEQ, T_BNE};
      if (m_slot[k]) begin
        e_rv[k] = 1'b1; e_rpc[k] = m_pend[k]; e_se[k] = ctl; m_slot[k] = 1'b0;
      end else if (ctl) begin
        p4 = (pc + 64'd4) & m;
        take = 1'b1;
        if (op == T_J || op == T_JAL) begin
          t = ((p4 >> (w - 4)) << (w - 4)) | (64'(target) * 64'd4);
        end else if (op == T_BEQ || op == T_BNE) begin
          sx = longint'($signed(imm));
          t = (pc + 64'd4 + 64'(sx * 4)) & m;
          take = (((rs_val & m) == (rt_val & m)) == (op == T_BEQ));
        end else begin
          t = rs_val & m;
          if (rs_val % 4 != 0) begin
            e_mis[k] = 1'b1;
            take = 1'b0;
          end
        end
        if (op == T_JAL || (op == T_JALR && !e_mis[k] && link_rd != 5'd0)) begin
          e_lwe[k] = 1'b1;
          e_la[k] = (op == T_JAL) ? 5'd31 : link_rd;
          e_ld[k] = (pc + 64'd8) & m;
        end
        if (take) begin
          if (k != 1) begin
            m_slot[k] = 1'b1; m_pend[k] = t;
          end else begin
            e_rv[k] = 1'b1; e_rpc[k] = t; m_bub[k] = 1'b1;
          end
        end
      end
    end
    e_rdy[k] = !m_bub[k];
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(T_JAL, 64'h0040_0010, '0, '0, 26'h0100040, '0, '0);
    tick();
    checks++; if (lwe0 !== 1'b0) begin errors++; $display("FAIL reset_link_we got %0b want 0", lwe0); end
    checks++; if (rv1 !== 1'b0) begin errors++; $display("FAIL reset_redirect got %0b want 0", rv1); end
    rst = 1'b0;
    idle();
    tick();
    checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", rdy0); end
    checks++; if (rdy1 !== 1'b1) begin errors++; $display("FAIL reset_in_ready_flush got %0b want 1", rdy1); end
    checks++; if (rpc0 !== 32'h0) begin errors++; $display("FAIL reset_redirect_pc got %h want 0", rpc0); end
    checks++; if (ld0 !== 32'h0 || la0 !== 5'd0) begin errors++; $display("FAIL reset_link got %h/%0d want 0/0", ld0, la0); end
    checks++; if ({rv0, lwe0, mis0, se0} !== 4'b0) begin errors++; $display("FAIL reset_pulses got %b want 0000", {rv0, lwe0, mis0, se0}); end
  endtask

  task automatic test_jal_slot;
    do_reset();
    drive(T_JAL, 64'h0040_0010, '0, '0, 26'h0100040, '0, '0);
    tick();
    checks++; if (lwe0 !== 1'b1) begin errors++; $display("FAIL jal_link_we got %0b want 1", lwe0); end
    checks++; if (la0 !== 5'd31) begin errors++; $display("FAIL jal_link_addr got %0d want 31", la0); end
    checks++; if (ld0 !== 32'h0040_0018) begin errors++; $display("FAIL jal_link_data got %h want 00400018", ld0); end
    checks++; if (rv0 !== 1'b0) begin errors++; $display("FAIL jal_early_redirect got %0b want 0", rv0); end
    checks++; if (rv1 !== 1'b1 || rpc1 !== 32'h0040_0100) begin errors++; $display("FAIL jal_flush_redirect got %0b/%h want 1/00400100", rv1, rpc1); end
    checks++; if (rdy1 !== 1'b0) begin errors++; $display("FAIL jal_flush_ready got %0b want 0", rdy1); end
    drive(T_NOP, 64'h0040_0014, '0, '0, '0, '0, '0);
    tick();
    checks++; if (rv0 !== 1'b1 || rpc0 !== 32'h0040_0100) begin errors++; $display("FAIL jal_slot_redirect got %0b/%h want 1/00400100", rv0, rpc0); end
    checks++; if (se0 !== 1'b0 || lwe0 !== 1'b0) begin errors++; $display("FAIL jal_slot_flags got se=%0b we=%0b want 0/0", se0, lwe0); end
    idle();
    tick();
    checks++; if (rv0 !== 1'b0) begin errors++; $display("FAIL jal_pulse_width got %0b want 0", rv0); end
    checks++; if (rpc0 !== 32'h0040_0100 || ld0 !== 32'h0040_0018) begin errors++; $display("FAIL jal_hold got %h/%h want 00400100/00400018", rpc0, ld0); end
  endtask

  task automatic test_branch;
    do_reset();
    drive(T_BEQ, 64'h1000, 64'd5, 64'd5, '0, 16'hFFFF, '0);
    tick();
    checks++; if (rv1 !== 1'b1 || rpc1 !== 32'h0000_1000) begin errors++; $display("FAIL beq_redirect got %0b/%h want 1/00001000", rv1, rpc1); end
    idle();
    tick();
    checks++; if (rdy1 !== 1'b1 || rv1 !== 1'b0) begin errors++; $display("FAIL beq_bubble_end got rdy=%0b rv=%0b want 1/0", rdy1, rv1); end
    drive(T_BNE, 64'h1000, 64'd5, 64'd5, '0, 16'hFFFF, '0);
    tick();
    checks++; if (rv1 !== 1'b0 || rdy1 !== 1'b1) begin errors++; $display("FAIL bne_not_taken got rv=%0b rdy=%0b want 0/1", rv1, rdy1); end
    checks++; if (rv0 !== 1'b1 || rpc0 !== 32'h0000_1000 || se0 !== 1'b1) begin errors++; $display("FAIL beq_slot_ctrl got %0b/%h/%0b want 1/00001000/1", rv0, rpc0, se0); end
  endtask

  task automatic test_jr_misalign;
    do_reset();
    drive(T_JR, 64'h100, 64'h0000_2002, '0, '0, '0, '0);
    tick();
    checks++; if (mis0 !== 1'b1 || mis1 !== 1'b1) begin errors++; $display("FAIL jr_misalign got %0b/%0b want 1/1", mis0, mis1); end
    checks++; if (rv0 !== 1'b0 || rv1 !== 1'b0 || lwe0 !== 1'b0) begin errors++; $display("FAIL jr_no_effect got rv=%0b%0b we=%0b want 00/0", rv0, rv1, lwe0); end
    checks++; if (rdy0 !== 1'b1 || rdy1 !== 1'b1) begin errors++; $display("FAIL jr_ready got %0b/%0b want 1/1", rdy0, rdy1); end
    drive(T_NOP, 64'h104, '0, '0, '0, '0, '0);
    tick();
    checks++; if (rv0 !== 1'b0 || mis0 !== 1'b0) begin errors++; $display("FAIL jr_stays_idle got rv=%0b mis=%0b want 0/0", rv0, mis0); end
  endtask

  task automatic test_slot_err;
    do_reset();
    drive(T_J, 64'h0040_0010, '0, '0, 26'h0100040, '0, '0);
    tick();
    checks++; if (rv0 !== 1'b0 || rdy0 !== 1'b1) begin errors++; $display("FAIL j_enter_slot got rv=%0b rdy=%0b want 0/1", rv0, rdy0); end
    drive(T_JR, 64'h0040_0014, 64'h3000, '0, '0, '0, '0);
    tick();
    checks++; if (rv0 !== 1'b1 || rpc0 !== 32'h0040_0100) begin errors++; $display("FAIL slot_err_redirect got %0b/%h want 1/00400100", rv0, rpc0); end
    checks++; if (se0 !== 1'b1) begin errors++; $display("FAIL slot_err_flag got %0b want 1", se0); end
    drive(T_NOP, 64'h0040_0100, '0, '0, '0, '0, '0);
    tick();
    checks++; if (rv0 !== 1'b0 || se0 !== 1'b0) begin errors++; $display("FAIL slot_err_no_second got rv=%0b se=%0b want 0/0", rv0, se0); end
    tick();
    checks++; if (rv0 !== 1'b0 || rpc0 !== 32'h0040_0100) begin errors++; $display("FAIL slot_err_target_kept got %0b/%h want 0/00400100", rv0, rpc0); end
  endtask

  task automatic test_flush_jalr;
    do_reset();
    drive(T_JALR, 64'h200, 64'h8000_0000, '0, '0, '0, 5'd0);
    tick();
    checks++; if (rv1 !== 1'b1 || rpc1 !== 32'h8000_0000) begin errors++; $display("FAIL jalr_redirect got %0b/%h want 1/80000000", rv1, rpc1); end
    checks++; if (lwe1 !== 1'b0) begin errors++; $display("FAIL jalr_rd0_link got %0b want 0", lwe1); end
    checks++; if (rdy1 !== 1'b0) begin errors++; $display("FAIL jalr_flush_ready got %0b want 0", rdy1); end
    drive(T_NOP, 64'h204, '0, '0, '0, '0, '0);
    tick();
    checks++; if (rdy1 !== 1'b1 || rv1 !== 1'b0) begin errors++; $display("FAIL jalr_flush_end got rdy=%0b rv=%0b want 1/0", rdy1, rv1); end
  endtask

  task automatic test_reset_in_slot_and_wrap;
    do_reset();
    drive(T_J, 64'h0040_0010, '0, '0, 26'h0100040, '0, '0);
    tick();
    rst = 1'b1;
    drive(T_NOP, 64'h0040_0014, '0, '0, '0, '0, '0);
    tick();
    rst = 1'b0;
    tick();
    checks++; if (rv0 !== 1'b0 || rpc0 !== 32'h0) begin errors++; $display("FAIL slot_reset_redirect got %0b/%h want 0/0", rv0, rpc0); end
    drive(T_BEQ, 64'hFFFF_FFFF_FFFF_FFFC, '0, '0, '0, 16'h0001, '0);
    tick();
    checks++; if (rv1 !== 1'b1 || rpc1 !== 32'h4) begin errors++; $display("FAIL wrap32_redirect got %0b/%h want 1/4", rv1, rpc1); end
    drive(T_NOP, 64'h0, '0, '0, '0, '0, '0);
    tick();
    checks++; if (rv2 !== 1'b1 || rpc2 !== 64'h4) begin errors++; $display("FAIL wrap64_redirect got %0b/%h want 1/4", rv2, rpc2); end
  endtask

  task automatic test_random;
    logic [5:0] ops[8] = '{T_J, T_JAL, T_JR, T_JALR, T_BEQ, T_BNE, T_NOP, T_ALU};
    do_reset();
    for (int k = 0; k < 3; k++) model_reset(k);
    for (int n = 0; n < 3000; n++) begin
      rst      = ($urandom_range(99) < 2);
      in_valid = ($urandom_range(99) < 80);
      op       = ops[$urandom_range(7)];
      pc       = {$urandom(), $urandom()} & ~64'h3;
      rs_val   = {$urandom(), $urandom()};
      if ($urandom_range(1) == 0) rs_val[1:0] = 2'b00;
      rt_val   = ($urandom_range(1) == 0) ? rs_val : {$urandom(), $urandom()};
      target   = 26'($urandom());
      imm      = 16'($urandom());
      link_rd  = ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom());
      for (int k = 0; k < 3; k++) model_step(k);
      tick();
      for (int k = 0; k < 3; k++) begin
        checks++; if (o_rdy[k] !== e_rdy[k]) begin errors++; $display("FAIL rand_in_ready u%0d n%0d got %0b want %0b", k, n, o_rdy[k], e_rdy[k]); end
        checks++; if (o_rv[k] !== e_rv[k]) begin errors++; $display("FAIL rand_redirect_valid u%0d n%0d got %0b want %0b", k, n, o_rv[k], e_rv[k]); end
        checks++; if (o_rpc[k] !== e_rpc[k]) begin errors++; $display("FAIL rand_redirect_pc u%0d n%0d got %h want %h", k, n, o_rpc[k], e_rpc[k]); end
        checks++; if (o_lwe[k] !== e_lwe[k]) begin errors++; $display("FAIL rand_link_we u%0d n%0d got %0b want %0b", k, n, o_lwe[k], e_lwe[k]); end
        checks++; if (o_la[k] !== e_la[k]) begin errors++; $display("FAIL rand_link_addr u%0d n%0d got %0d want %0d", k, n, o_la[k], e_la[k]); end
        checks++; if (o_ld[k] !== e_ld[k]) begin errors++; $display("FAIL rand_link_data u%0d n%0d got %h want %h", k, n, o_ld[k], e_ld[k]); end
        checks++; if (o_mis[k] !== e_mis[k]) begin errors++; $display("FAIL rand_misalign u%0d n%0d got %0b want %0b", k, n, o_mis[k], e_mis[k]); end
        checks++; if (o_se[k] !== e_se[k]) begin errors++; $display("FAIL rand_slot_err u%0d n%0d got %0b want %0b", k, n, o_se[k], e_se[k]); end
      end
    end
    rst = 1'b0;
    idle();
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_jal_slot();
    test_branch();
    test_jr_misalign();
    test_slot_err();
    test_flush_jalr();
    test_reset_in_slot_and_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
